arb_mux4_1: RTL and testbench



---
 rtl/arb_mux4_1.sv | 103 ++++++++++
 tb/tb_arb_mux4_1.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux4_1.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux4_1
// Brief    : 4:1 round-robin arbitrating mux with registered, tagged output
// Revision : 1.0
// ============================================================================
module arb_mux4_1 #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic             A_valid,
    input  logic             B_valid,
    input  logic             C_valid,
    input  logic             D_valid,
    output logic             A_ready,
    output logic             B_ready,
    output logic             C_ready,
    output logic             D_ready,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_sel;
    logic             r_out_valid;
    logic [1:0]       r_prio;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       w_valid;
    logic             w_any;
    logic             w_load_en;
    logic [1:0]       w_grant;
    logic [WIDTH-1:0] w_data;

    assign w_valid   = {D_valid, C_valid, B_valid, A_valid};
    assign w_any     = |w_valid;
    assign w_load_en = !r_out_valid || out_ready;

    // Scan downwards so the channel closest to the pointer is written last and wins.
    always_comb begin
        w_grant = r_prio;
        for (int k = 3; k >= 0; k--) begin
            if (w_valid[r_prio + 2'(k)]) begin
                w_grant = r_prio + 2'(k);
            end
        end
    end

    always_comb begin
        w_data = A;
        case (w_grant)
            2'd0:    w_data = A;
            2'd1:    w_data = B;
            2'd2:    w_data = C;
            default: w_data = D;
        endcase
    end

    assign A_ready = rst_n && w_load_en && A_valid && (w_grant == 2'd0);
    assign B_ready = rst_n && w_load_en && B_valid && (w_grant == 2'd1);
    assign C_ready = rst_n && w_load_en && C_valid && (w_grant == 2'd2);
    assign D_ready = rst_n && w_load_en && D_valid && (w_grant == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_sel       <= 2'b00;
            r_out_valid <= 1'b0;
            r_prio      <= 2'd0;
            r_cnt       <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load_en) begin
                if (w_any) begin
                    r_out       <= w_data;
                    r_sel       <= w_grant;
                    r_out_valid <= 1'b1;
                    r_prio      <= w_grant + 2'd1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out       = r_out;
    assign sel       = r_sel;
    assign out_valid = r_out_valid;
    assign xfer_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux4_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_mux4_1
// Brief    : Self-checking bench: directed vector table plus scoreboard runs
// Revision : 1.0
// ============================================================================
module tb_arb_mux4_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] A, B, C, D;
    logic       A_valid, B_valid, C_valid, D_valid;
    logic       A_ready, B_ready, C_ready, D_ready;
    logic [2:0] out;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] xfer_cnt;

    arb_mux4_1 #(.WIDTH(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .A(A), .B(B), .C(C), .D(D),
        .A_valid(A_valid), .B_valid(B_valid), .C_valid(C_valid), .D_valid(D_valid),
        .A_ready(A_ready), .B_ready(B_ready), .C_ready(C_ready), .D_ready(D_ready),
        .out(out), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [2:0] a, b, c, d;
        logic       ordy;
        logic [3:0] erdy;
        logic       eov;
        logic [2:0] eout;
        logic [1:0] esel;
        logic [7:0] ecnt;
    } vec_t;

    typedef struct {
        logic [2:0] d;
        logic [1:0] s;
    } word_t;

    int    n_vec = 0;
    int    n_err = 0;
    vec_t  tbl[25];
    word_t sbq[$];
    logic [1:0] m_prio;
    logic [7:0] m_cnt;
    logic [3:0] m_rdy;

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [2:0] a, logic [2:0] b,
                                logic [2:0] c, logic [2:0] d, logic ordy, logic [3:0] erdy,
                                logic eov, logic [2:0] eout, logic [1:0] esel, logic [7:0] ecnt);
        vec_t r;
        r.rst = rst; r.v = v; r.a = a; r.b = b; r.c = c; r.d = d; r.ordy = ordy;
        r.erdy = erdy; r.eov = eov; r.eout = eout; r.esel = esel; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mgrant(logic [3:0] v, logic [1:0] p);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (int'(p) + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [2:0] chan_data(int g);
        case (g)
            0:       return A;
            1:       return B;
            2:       return C;
            default: return D;
        endcase
    endfunction

    function automatic logic [3:0] dut_rdy();
        return {D_ready, C_ready, B_ready, A_ready};
    endfunction

    task automatic drive(logic rst, logic [3:0] v, logic [2:0] a, logic [2:0] b,
                         logic [2:0] c, logic [2:0] d, logic ordy);
        rst_n = rst;
        {D_valid, C_valid, B_valid, A_valid} = v;
        A = a; B = b; C = c; D = d;
        out_ready = ordy;
    endtask

    task automatic model_reset();
        sbq.delete();
        m_prio = 2'd0;
        m_cnt  = 8'd0;
    endtask

    // Called #1 after inputs are driven; compares, then advances the model by one edge.
    task automatic sb_cycle();
        int    g;
        logic  load;
        word_t w;
        g      = mgrant({D_valid, C_valid, B_valid, A_valid}, m_prio);
        load   = (sbq.size() == 0) || out_ready;
        m_rdy  = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
        check("sb_ready", int'(dut_rdy()), int'(m_rdy));
        check("sb_out_valid", int'(out_valid), int'(sbq.size() != 0));
        if (sbq.size() != 0) begin
            check("sb_out", int'(out), int'(sbq[0].d));
            check("sb_sel", int'(sel), int'(sbq[0].s));
        end
        check("sb_xfer_cnt", int'(xfer_cnt), int'(m_cnt));
        if (sbq.size() != 0 && out_ready) begin
            void'(sbq.pop_front());
            m_cnt = m_cnt + 8'd1;
        end
        if (load && g >= 0) begin
            w.d = chan_data(g);
            w.s = 2'(g);
            sbq.push_back(w);
            m_prio = 2'(g + 1);
        end
    endtask

    initial begin
        logic [3:0] pv;
        logic [2:0] pd[4];

        //          rst v        a     b     c     d     ordy erdy     ov    out   sel    cnt
        tbl[0]  = mk(0, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0000, 1'b0, 3'd0, 2'd0, 8'd0);
        tbl[1]  = mk(0, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0000, 1'b0, 3'd0, 2'd0, 8'd0);
        tbl[2]  = mk(1, 4'b0100, 3'd1, 3'd2, 3'd5, 3'd4, 1, 4'b0100, 1'b0, 3'd0, 2'd0, 8'd0);
        tbl[3]  = mk(1, 4'b0000, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0000, 1'b1, 3'd5, 2'd2, 8'd0);
        tbl[4]  = mk(1, 4'b0000, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0000, 1'b0, 3'd5, 2'd2, 8'd1);
        tbl[5]  = mk(0, 4'b0000, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0000, 1'b0, 3'd5, 2'd2, 8'd1);
        tbl[6]  = mk(1, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0001, 1'b0, 3'd0, 2'd0, 8'd0);
        tbl[7]  = mk(1, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0010, 1'b1, 3'd1, 2'd0, 8'd0);
        tbl[8]  = mk(1, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0100, 1'b1, 3'd2, 2'd1, 8'd1);
        tbl[9]  = mk(1, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b1000, 1'b1, 3'd3, 2'd2, 8'd2);
        tbl[10] = mk(1, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0001, 1'b1, 3'd4, 2'd3, 8'd3);
        tbl[11] = mk(1, 4'b0010, 3'd1, 3'd6, 3'd3, 3'd4, 1, 4'b0010, 1'b1, 3'd1, 2'd0, 8'd4);
        tbl[12] = mk(1, 4'b1001, 3'd1, 3'd6, 3'd3, 3'd4, 0, 4'b0000, 1'b1, 3'd6, 2'd1, 8'd5);
        tbl[13] = mk(1, 4'b1001, 3'd1, 3'd6, 3'd3, 3'd4, 0, 4'b0000, 1'b1, 3'd6, 2'd1, 8'd5);
        tbl[14] = mk(1, 4'b1001, 3'd1, 3'd6, 3'd3, 3'd4, 0, 4'b0000, 1'b1, 3'd6, 2'd1, 8'd5);
        tbl[15] = mk(1, 4'b1001, 3'd1, 3'd6, 3'd3, 3'd4, 1, 4'b1000, 1'b1, 3'd6, 2'd1, 8'd5);
        tbl[16] = mk(1, 4'b1001, 3'd1, 3'd6, 3'd3, 3'd4, 1, 4'b0001, 1'b1, 3'd4, 2'd3, 8'd6);
        tbl[17] = mk(1, 4'b0101, 3'd7, 3'd2, 3'd2, 3'd4, 1, 4'b0100, 1'b1, 3'd1, 2'd0, 8'd7);
        tbl[18] = mk(1, 4'b0101, 3'd7, 3'd2, 3'd2, 3'd4, 1, 4'b0001, 1'b1, 3'd2, 2'd2, 8'd8);
        tbl[19] = mk(1, 4'b0101, 3'd7, 3'd2, 3'd2, 3'd4, 1, 4'b0100, 1'b1, 3'd7, 2'd0, 8'd9);
        tbl[20] = mk(1, 4'b0101, 3'd7, 3'd2, 3'd2, 3'd4, 1, 4'b0001, 1'b1, 3'd2, 2'd2, 8'd10);
        tbl[21] = mk(0, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0000, 1'b1, 3'd7, 2'd0, 8'd11);
        tbl[22] = mk(1, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0001, 1'b0, 3'd0, 2'd0, 8'd0);
        tbl[23] = mk(1, 4'b0000, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0000, 1'b1, 3'd1, 2'd0, 8'd0);
        tbl[24] = mk(1, 4'b0000, 3'd1, 3'd2, 3'd3, 3'd4, 1, 4'b0000, 1'b0, 3'd1, 2'd0, 8'd1);

        drive(0, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1);
        @(posedge clk);

        // Directed table: each row's expectations are the values visible before its edge.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].ordy);
            #1;
            check($sformatf("row%0d_ready", i), int'(dut_rdy()), int'(tbl[i].erdy));
            check($sformatf("row%0d_out_valid", i), int'(out_valid), int'(tbl[i].eov));
            check($sformatf("row%0d_out", i), int'(out), int'(tbl[i].eout));
            check($sformatf("row%0d_sel", i), int'(sel), int'(tbl[i].esel));
            check($sformatf("row%0d_xfer_cnt", i), int'(xfer_cnt), int'(tbl[i].ecnt));
        end

        // Random traffic with random backpressure against the scoreboard.
        @(negedge clk);
        drive(0, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 1);
        model_reset();
        pv = 4'b0000;
        for (int ch = 0; ch < 4; ch++) pd[ch] = 3'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                if (!pv[ch] && $urandom_range(0, 2) != 0) begin
                    pv[ch] = 1'b1;
                    pd[ch] = 3'($urandom_range(0, 7));
                end
            end
            drive(1, pv, pd[0], pd[1], pd[2], pd[3], $urandom_range(0, 3) != 0);
            #1;
            sb_cycle();
            pv = pv & ~m_rdy;
        end

        // Continuous all-valid stream long enough to wrap the transfer counter.
        @(negedge clk);
        drive(0, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 1);
        model_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            drive(1, 4'b1111, 3'd1, 3'd2, 3'd3, 3'd4, 1);
            #1;
            sb_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
